// File: rtl/dcm_reset_sequencer_pkg.sv
// Shared state encoding and default timing for the DCM reset sequencer.
package dcm_reset_sequencer_pkg;

    typedef enum logic [3:0] {
        HOLD    = 4'd0,
        WAIT66  = 4'd1,
        WAIT133 = 4'd2,
        WAITPH  = 4'd3,
        SETTLE  = 4'd4,
        RUN     = 4'd5,
        RETRY   = 4'd6,
        FAULT   = 4'd7
    } seq_state_t;

    localparam int unsigned DEF_RST_PULSE_CYCLES = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT     = 65535;
    localparam int unsigned DEF_SETTLE_CYCLES    = 1024;
    localparam int unsigned DEF_MAX_RETRIES      = 3;

    // Width of the shared phase counter; it only ever needs to reach max-1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dcm_reset_sequencer_sync.sv
// Two-flop synchronizer with asynchronous preset/clear to a selectable value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk100,
    input  logic rstRaw,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk100 or posedge rstRaw) begin
        if (rstRaw) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Orders DCM reset release, supervises LOCKED with timeout/retry and issues rstSys.
module dcm_reset_sequencer
    import dcm_reset_sequencer_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT     = DEF_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES
) (
    input  logic       clk100,
    input  logic       rstRaw,
    input  logic       lock100,
    input  logic       lock66,
    input  logic       lock133,
    input  logic       lockPhase,
    output logic       dcmRst66,
    output logic       dcmRst133,
    output logic       dcmRstPhase,
    output logic       rstSys,
    output logic [3:0] state,
    output logic [1:0] retryCount,
    output logic [3:0] lossCount,
    output logic       fault
);

    localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

    logic rstSync, lk100, lk66, lk133, lkPh;

    sync2 #(.RST_VAL(1'b1)) u_rel   (.clk100(clk100), .rstRaw(rstRaw), .d(1'b0),      .q(rstSync));
    sync2 #(.RST_VAL(1'b0)) u_lk100 (.clk100(clk100), .rstRaw(rstRaw), .d(lock100),   .q(lk100));
    sync2 #(.RST_VAL(1'b0)) u_lk66  (.clk100(clk100), .rstRaw(rstRaw), .d(lock66),    .q(lk66));
    sync2 #(.RST_VAL(1'b0)) u_lk133 (.clk100(clk100), .rstRaw(rstRaw), .d(lock133),   .q(lk133));
    sync2 #(.RST_VAL(1'b0)) u_lkPh  (.clk100(clk100), .rstRaw(rstRaw), .d(lockPhase), .q(lkPh));

    seq_state_t    cur, nxt;
    logic [CW-1:0] cnt, cntNxt;
    logic [1:0]    retryNxt;
    logic [3:0]    lossNxt;
    logic          rst66Nxt, rst133Nxt, rstPhNxt, rstSysNxt, faultNxt;
    logic          allLocked, timeoutHit;

    assign state = cur;

    always_comb begin
        nxt        = cur;
        retryNxt   = retryCount;
        lossNxt    = lossCount;
        allLocked  = lk100 & lk66 & lk133 & lkPh;
        timeoutHit = (cnt == TO_LAST);

        unique case (cur)
            HOLD:    if (lk100 && cnt == PULSE_LAST) nxt = WAIT66;
            WAIT66: begin
                if (!lk100)          nxt = HOLD;
                else if (lk66)       nxt = WAIT133;
                else if (timeoutHit) nxt = RETRY;
            end
            WAIT133: begin
                if (!lk100)          nxt = HOLD;
                else if (!lk66)      nxt = RETRY;
                else if (lk133)      nxt = WAITPH;
                else if (timeoutHit) nxt = RETRY;
            end
            WAITPH: begin
                if (!lk100)              nxt = HOLD;
                else if (!lk66 || !lk133) nxt = RETRY;
                else if (lkPh)           nxt = SETTLE;
                else if (timeoutHit)     nxt = RETRY;
            end
            SETTLE: begin
                if (!lk100)                  nxt = HOLD;
                else if (!allLocked)         nxt = RETRY;
                else if (cnt == SETTLE_LAST) begin
                    nxt      = RUN;
                    retryNxt = '0;
                end
            end
            RUN: begin
                if (!allLocked) begin
                    nxt = HOLD;
                    if (lossCount != '1) lossNxt = lossCount + 4'd1;
                end
            end
            RETRY: begin
                if (retryCount == RETRY_MAX) nxt = FAULT;
                else begin
                    nxt      = HOLD;
                    retryNxt = retryCount + 2'd1;
                end
            end
            FAULT:   nxt = FAULT;
            default: nxt = HOLD;
        endcase

        // Counter only runs in timed states, restarting on any transition or lk100 dropout in HOLD.
        cntNxt = '0;
        if (nxt == cur && cur inside {HOLD, WAIT66, WAIT133, WAITPH, SETTLE}
            && !(cur == HOLD && !lk100))
            cntNxt = cnt + CW'(1);

        rst66Nxt  = !(nxt inside {WAIT66, WAIT133, WAITPH, SETTLE, RUN});
        rst133Nxt = !(nxt inside {WAIT133, WAITPH, SETTLE, RUN});
        rstPhNxt  = !(nxt inside {WAITPH, SETTLE, RUN});
        rstSysNxt = (nxt != RUN);
        faultNxt  = (nxt == FAULT);
    end

    always_ff @(posedge clk100 or posedge rstRaw) begin
        if (rstRaw) begin
            cur         <= HOLD;
            cnt         <= '0;
            retryCount  <= '0;
            lossCount   <= '0;
            dcmRst66    <= 1'b1;
            dcmRst133   <= 1'b1;
            dcmRstPhase <= 1'b1;
            rstSys      <= 1'b1;
            fault       <= 1'b0;
        end else if (!rstSync) begin
            cur         <= nxt;
            cnt         <= cntNxt;
            retryCount  <= retryNxt;
            lossCount   <= lossNxt;
            dcmRst66    <= rst66Nxt;
            dcmRst133   <= rst133Nxt;
            dcmRstPhase <= rstPhNxt;
            rstSys      <= rstSysNxt;
            fault       <= faultNxt;
        end
    end

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Scoreboard bench for dcm_reset_sequencer with behavioural DCM lock responders.
module tb_dcm_reset_sequencer;

    logic       clk100 = 1'b0;
    logic       rstRaw;
    logic       lock100;
    logic       lock66, lock133, lockPhase;
    logic       dcmRst66, dcmRst133, dcmRstPhase, rstSys, fault;
    logic [3:0] state, lossCount;
    logic [1:0] retryCount;

    logic       lkm [3];
    bit         en  [3];
    logic [2:0] drop;
    logic [2:0] rstv;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    always #5 clk100 = ~clk100;

    assign rstv      = {dcmRstPhase, dcmRst133, dcmRst66};
    assign lock66    = lkm[0] & ~drop[0];
    assign lock133   = lkm[1] & ~drop[1];
    assign lockPhase = lkm[2] & ~drop[2];

    dcm_reset_sequencer #(
        .RST_PULSE_CYCLES(4),
        .LOCK_TIMEOUT(100),
        .SETTLE_CYCLES(16),
        .MAX_RETRIES(2)
    ) dut (
        .clk100(clk100), .rstRaw(rstRaw), .lock100(lock100), .lock66(lock66),
        .lock133(lock133), .lockPhase(lockPhase), .dcmRst66(dcmRst66),
        .dcmRst133(dcmRst133), .dcmRstPhase(dcmRstPhase), .rstSys(rstSys),
        .state(state), .retryCount(retryCount), .lossCount(lossCount), .fault(fault)
    );

    // Each downstream DCM loses lock in reset and locks 10 cycles after its reset falls.
    for (genvar g = 0; g < 3; g++) begin : g_lock
        initial begin
            lkm[g] = 1'b0;
            forever begin
                @(rstv[g]);
                if (rstv[g] === 1'b1) lkm[g] = 1'b0;
                else if (rstv[g] === 1'b0 && en[g]) begin
                    for (int i = 0; i < 10 && rstv[g] === 1'b0; i++) @(posedge clk100);
                    #2;
                    if (rstv[g] === 1'b0 && en[g]) lkm[g] = 1'b1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            check_eq("sb_underflow", sbq.size(), 1);
        end else begin
            e = sbq.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag,
                              output int n);
        n = 0;
        while (state !== s && n < budget) begin
            @(posedge clk100); #1;
            n++;
        end
        if (state !== s) check_eq({tag, "_timeout"}, state, s);
    endtask

    task automatic pulse_reset();
        @(negedge clk100) rstRaw = 1'b1;
        repeat (3) @(negedge clk100);
        rstRaw = 1'b0;
    endtask

    // Drops one downstream lock for a single cycle and returns cycles until rstSys rises.
    task automatic drop_lock(input int idx, output int n);
        @(negedge clk100) drop[idx] = 1'b1;
        n = 0;
        while (rstSys !== 1'b1 && n < 10) begin
            @(posedge clk100); #1;
            n++;
            if (n == 1) drop[idx] = 1'b0;
        end
        drop[idx] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
        $fatal(1);
    end

    initial begin
        int n, bad;
        rstRaw  = 1'b0;
        lock100 = 1'b0;
        drop    = '0;
        en[0] = 1'b1; en[1] = 1'b1; en[2] = 1'b1;
        #1 rstRaw = 1'b1;
        repeat (3) @(negedge clk100);

        // Reset state
        sb_push("rst_state", 0);    sb_pop(state);
        sb_push("rst_dcmRst66", 1); sb_pop(dcmRst66);
        sb_push("rst_dcmRst133", 1); sb_pop(dcmRst133);
        sb_push("rst_dcmRstPh", 1); sb_pop(dcmRstPhase);
        sb_push("rst_rstSys", 1);   sb_pop(rstSys);
        sb_push("rst_fault", 0);    sb_pop(fault);
        sb_push("rst_loss", 0);     sb_pop(lossCount);
        sb_push("rst_retry", 0);    sb_pop(retryCount);

        // Clean bring-up: 2 release-sync cycles plus 4 HOLD cycles before WAIT66
        lock100 = 1'b1;
        rstRaw  = 1'b0;
        sb_push("rel_to_wait66", 6);
        wait_state(4'd1, 50, "up_wait66", n); sb_pop(n);
        sb_push("up66_rst66", 0);    sb_pop(dcmRst66);
        sb_push("up66_rst133", 1);   sb_pop(dcmRst133);
        sb_push("up66_rstPh", 1);    sb_pop(dcmRstPhase);
        wait_state(4'd2, 50, "up_wait133", n);
        sb_push("up133_rst133", 0);  sb_pop(dcmRst133);
        sb_push("up133_rstPh", 1);   sb_pop(dcmRstPhase);
        wait_state(4'd3, 50, "up_waitph", n);
        sb_push("upph_rstPh", 0);    sb_pop(dcmRstPhase);
        wait_state(4'd4, 50, "up_settle", n);
        n = 0;
        while (rstSys !== 1'b0 && n < 100) begin
            @(posedge clk100); #1;
            n++;
        end
        sb_push("settle_cycles", 16); sb_pop(n);
        sb_push("up_state", 5);       sb_pop(state);
        sb_push("up_retry", 0);       sb_pop(retryCount);

        // Lock loss in RUN
        drop_lock(1, n);
        sb_push("loss_latency", 3);  sb_pop(n);
        sb_push("loss_count", 1);    sb_pop(lossCount);
        sb_push("loss_state", 0);    sb_pop(state);
        wait_state(4'd5, 500, "loss_rerun", n);
        sb_push("loss_rerun_state", 5); sb_pop(state);
        sb_push("loss_rerun_count", 1); sb_pop(lossCount);
        sb_push("loss_rerun_rstSys", 0); sb_pop(rstSys);

        // Async reset mid-SETTLE
        drop_lock(2, n);
        sb_push("loss2_count", 2);   sb_pop(lossCount);
        wait_state(4'd4, 500, "ar_settle", n);
        @(posedge clk100); #3 rstRaw = 1'b1;
        #1;
        sb_push("ar_rst66", 1);  sb_pop(dcmRst66);
        sb_push("ar_rst133", 1); sb_pop(dcmRst133);
        sb_push("ar_rstPh", 1);  sb_pop(dcmRstPhase);
        sb_push("ar_rstSys", 1); sb_pop(rstSys);
        sb_push("ar_state", 0);  sb_pop(state);
        sb_push("ar_loss", 0);   sb_pop(lossCount);
        sb_push("ar_fault", 0);  sb_pop(fault);
        sb_push("ar_retry", 0);  sb_pop(retryCount);

        // Timeout -> retry -> fault
        en[0] = 1'b0;
        repeat (2) @(negedge clk100);
        rstRaw = 1'b0;
        wait_state(4'd1, 50, "to_wait66", n);
        n = 0;
        while (state === 4'd1 && n < 200) begin
            @(posedge clk100); #1;
            n++;
        end
        sb_push("to_cycles", 100);   sb_pop(n);
        sb_push("to_retry_state", 6); sb_pop(state);
        @(posedge clk100); #1;
        sb_push("to_hold_state", 0); sb_pop(state);
        sb_push("to_retry_cnt", 1);  sb_pop(retryCount);
        wait_state(4'd7, 1000, "to_fault", n);
        sb_push("flt_fault", 1);  sb_pop(fault);
        sb_push("flt_rst66", 1);  sb_pop(dcmRst66);
        sb_push("flt_rst133", 1); sb_pop(dcmRst133);
        sb_push("flt_rstPh", 1);  sb_pop(dcmRstPhase);
        sb_push("flt_rstSys", 1); sb_pop(rstSys);
        sb_push("flt_retry", 2);  sb_pop(retryCount);
        en[0] = 1'b1;
        repeat (60) @(posedge clk100);
        #1;
        sb_push("flt_sticky_state", 7); sb_pop(state);
        sb_push("flt_sticky_fault", 1); sb_pop(fault);

        // Retry recovery: lock66 only on the second attempt
        en[0] = 1'b0;
        pulse_reset();
        wait_state(4'd6, 300, "rr_retry", n);
        en[0] = 1'b1;
        wait_state(4'd4, 500, "rr_settle", n);
        sb_push("rr_settle_retry", 1); sb_pop(retryCount);
        wait_state(4'd5, 100, "rr_run", n);
        sb_push("rr_state", 5);  sb_pop(state);
        sb_push("rr_retry", 0);  sb_pop(retryCount);
        sb_push("rr_fault", 0);  sb_pop(fault);

        // Upstream loss during WAITPH
        en[2] = 1'b0;
        pulse_reset();
        wait_state(4'd3, 300, "ul_waitph", n);
        @(negedge clk100);
        en[0]   = 1'b0;
        drop[0] = 1'b1;
        wait_state(4'd6, 10, "ul_retry", n);
        sb_push("ul_state", 6); sb_pop(state);
        sb_push("ul_rstPh_retry", 1); sb_pop(dcmRstPhase);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk100); #1;
            if (dcmRstPhase !== 1'b1) bad++;
            if (i == 0) begin
                sb_push("ul_retry_cnt", 1); sb_pop(retryCount);
            end
        end
        sb_push("ul_rstPh_low_cycles", 0); sb_pop(bad);
        sb_push("ul_end_state", 1);        sb_pop(state);
        sb_push("ul_end_rst133", 1);       sb_pop(dcmRst133);

        check_eq("sb_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
